npu_requant: RTL
================

Name: npu_requant

Overview:
- Downstream stage of the 8x8 NPU MAC array.
- Consumes the eight signed 32-bit row accumulators of one matrix-vector pass as a stream.
- Per element: adds a per-row bias, applies a fixed-point scale (multiply, rounding right shift), optional ReLU, then saturates to INT8 or UINT8.
- Packs four results per 32-bit little-endian word, so the next layer's input buffer can be written directly.

Parameters:
- NROWS, 8, elements per frame (row index width = 3).
- MULT_W, 16, width of unsigned scale multiplier.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- cfg_we  in  1  config write strobe.
- cfg_addr  in  4  0-7 bias[row], 8 mult, 9 shift, 10 ctrl, 11 clear sat_cnt.
- cfg_wdata  in  32  config data. bias signed 32; mult [15:0]; shift [4:0]; ctrl [0]=relu_en, [1]=out_unsigned.
- in_valid  in  1  accumulator valid.
- in_ready  out  1  stage can accept.
- in_data  in  32  signed accumulator.
- in_last  in  1  final element of frame (may arrive before 8th).
- out_valid  out  1  packed word valid.
- out_ready  in  1  consumer accepts.
- out_data  out  32  packed bytes, element k in bits [8(k%4)+7 : 8(k%4)].
- out_last  out  1  word holds the frame's final element.
- busy  out  1  frame in progress or pipeline non-empty.
- sat_cnt  out  16  saturating count of clamped elements.

Behaviour:
- Reset (rst=1 at clk edge):
  - out_valid=0, out_data=0, out_last=0, sat_cnt=0, busy=0.
  - Row index=0, pack register=0, stage valids=0.
  - bias[*]=0, mult=1, shift=0, ctrl=0.
  - A frame in flight is discarded. Reset mid-frame yields no partial output.
- Handshake and stall:
  - in_ready = !out_valid || out_ready (combinational).
  - Pipeline advances only when in_ready=1. Input transfers on in_valid&&in_ready.
  - Output transfers on out_valid&&out_ready.
  - out_data and out_last are stable while out_valid=1 && !out_ready.
- Row index:
  - Increments per accepted element.
  - Returns to 0 after index 7 or after an element with in_last=1.
  - Frame end = index 7 or in_last.
- S1 (registered on accept): sum = acc + bias[idx], computed 33-bit signed with no wrap. prod = sum * mult (mult zero-extended), 50-bit signed.
- S2 (registered when S1 valid and advancing):
  - r = shift==0 ? prod : (prod + 2^(shift-1)) >>> shift. This is round-half-up toward +inf, arithmetic shift.
  - If relu_en and r<0, r=0.
  - Signed clamp: [-128,127]. Unsigned clamp: [0,255].
  - sat_cnt increments (saturating at 0xFFFF) when clamping changed the value. ReLU zeroing does not count as clamping.
  - Byte is written into the pack register at lane idx%4.
- Word emit:
  - When the written lane is 3 or the element is frame end, the pack register moves to out_data with out_valid=1. out_last=frame end.
  - Unwritten lanes of a partial word are 0. The pack register clears after emit.
- Latency: element accepted at edge N; its word is valid after edge N+2 when no stall occurs. Throughput is 1 element/cycle.
- Config writes:
  - Take effect the next cycle.
  - Writes to 0-10 are ignored while busy=1.
  - A write to 11 clears sat_cnt at any time. If it coincides with an increment, the clear wins.
  - Unused addresses 12-15 are ignored.
- busy = row index!=0 || S1 valid || S2/pack non-empty || out_valid.

Test Plan:
- Default config, signed, frame 1,-1,200,-200,0,0,0,0 -> words 0x807FFF01 then 0x00000000 (last=1); sat_cnt=2.
- mult=3, shift=2, inputs 5,-5,6,-6 -> 15→4, -15→-4, 18→5 (4.5 rounds up), -18→-4 (-4.5 rounds up) -> word 0xFC05FC04.
- bias[0]=-10, ctrl=3 (relu, unsigned), inputs 3,300,-7 with in_last on 3rd -> 0 (-7 relu), 255 (clamped), 0 -> word 0x0000FF00, out_last=1; sat_cnt=1.
- Hold out_ready=0 for 5 cycles after first word with in_valid=1 -> in_ready=0, out_data unchanged, no elements lost; after release all 8 results appear in order.
- Assert rst after 3 accepted elements -> no output word, busy=0; next 8-element frame packs from lane 0.
- cfg_we to addr 8 while busy -> mult unchanged. Write to 11 during the same cycle as a clamp -> sat_cnt=0.

Source files
------------

// File: rtl/npu_requant.sv
// npu_requant: requantization stage behind the 8x8 NPU MAC array.
//
// Takes the signed 32-bit row accumulators of one matrix-vector pass as a stream.
// For each element it adds a per-row bias, scales by an unsigned multiplier, applies a
// rounding arithmetic right shift (round half up), optionally applies ReLU, and
// saturates to INT8 or UINT8. Four results are packed little-endian into each 32-bit
// output word.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   cfg_we/addr/wdata     config: 0-7 bias[row], 8 mult, 9 shift, 10 ctrl
//                         ({out_unsigned, relu_en}), 11 clear sat_cnt
//   in_valid/ready/data   accumulator stream, in_last ends a frame early
//   out_valid/ready/data  packed result words, out_last marks the frame's final word
//   busy                  frame in progress or pipeline non-empty
//   sat_cnt               saturating count of clamped elements
//
// Pipeline: S1 (bias + multiply) -> S2 (round, ReLU, clamp) -> pack/output register.
// All three stages advance together whenever in_ready is high.
module npu_requant #(
  parameter int unsigned NROWS  = 8,
  parameter int unsigned MULT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cfg_we,
  input  logic [3:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        busy,
  output logic [15:0] sat_cnt
);

  localparam int unsigned IdxW  = $clog2(NROWS);
  localparam int unsigned SumW  = 33;
  localparam int unsigned ProdW = SumW + MULT_W + 1;

  // Configuration registers
  logic signed [31:0] bias_q [NROWS];
  logic signed [31:0] bias_d [NROWS];
  logic [MULT_W-1:0]  mult_q, mult_d;
  logic [4:0]         shift_q, shift_d;
  logic               relu_q, relu_d;
  logic               uns_q, uns_d;
  logic [15:0]        sat_q, sat_d;

  // Frame position
  logic [IdxW-1:0]    idx_q, idx_d;

  // S1: scaled product
  logic                    s1_valid_q, s1_valid_d;
  logic signed [ProdW-1:0] s1_prod_q, s1_prod_d;
  logic [1:0]              s1_lane_q, s1_lane_d;
  logic                    s1_end_q, s1_end_d;

  // S2: quantized byte
  logic       s2_valid_q, s2_valid_d;
  logic [7:0] s2_byte_q, s2_byte_d;
  logic [1:0] s2_lane_q, s2_lane_d;
  logic       s2_end_q, s2_end_d;

  // Pack and output registers
  logic [31:0] pack_q, pack_d;
  logic        pack_vld_q, pack_vld_d;
  logic        out_valid_q, out_valid_d;
  logic [31:0] out_data_q, out_data_d;
  logic        out_last_q, out_last_d;

  logic advance, accept, frame_end, cfg_ok;

  logic signed [SumW-1:0]  sum;
  logic signed [ProdW-1:0] sum_ext, mult_ext, prod;

  logic signed [ProdW:0] p_ext, half, rnd, rnd_sh, r_relu, hi_v, lo_v;
  logic [7:0]            q_byte;
  logic                  q_clamped;

  logic [31:0] merged;
  logic        emit;

  assign in_ready  = !out_valid_q || out_ready;
  assign advance   = in_ready;
  assign accept    = in_valid && advance;
  assign frame_end = (idx_q == IdxW'(NROWS - 1)) || in_last;

  assign busy      = (idx_q != '0) || s1_valid_q || s2_valid_q || pack_vld_q || out_valid_q;
  assign cfg_ok    = cfg_we && !busy && (cfg_addr <= 4'd10);

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign sat_cnt   = sat_q;

  // S1 arithmetic: 33-bit bias sum, then signed x zero-extended multiply.
  always_comb begin
    sum      = {in_data[31], in_data} + {bias_q[idx_q][31], bias_q[idx_q]};
    sum_ext  = {{(ProdW - SumW){sum[SumW-1]}}, sum};
    mult_ext = {{(ProdW - MULT_W){1'b0}}, mult_q};
    prod     = sum_ext * mult_ext;
  end

  // S2 arithmetic: round half up toward +inf, ReLU, clamp.
  always_comb begin
    p_ext  = {s1_prod_q[ProdW-1], s1_prod_q};
    half   = (shift_q == 5'd0) ? '0 : ((ProdW + 1)'(1) << (shift_q - 5'd1));
    rnd    = p_ext + half;
    rnd_sh = rnd >>> shift_q;
    r_relu = (relu_q && rnd_sh[ProdW]) ? '0 : rnd_sh;
    hi_v   = uns_q ? (ProdW + 1)'(255) : (ProdW + 1)'(127);
    lo_v   = uns_q ? '0 : {{(ProdW - 6){1'b1}}, 7'd0};
    q_clamped = 1'b0;
    if (r_relu > hi_v) begin
      q_byte    = hi_v[7:0];
      q_clamped = 1'b1;
    end else if (r_relu < lo_v) begin
      q_byte    = lo_v[7:0];
      q_clamped = 1'b1;
    end else begin
      q_byte    = r_relu[7:0];
    end
  end

  assign merged = pack_q | (32'(s2_byte_q) << {s2_lane_q, 3'b000});
  assign emit   = s2_valid_q && ((s2_lane_q == 2'd3) || s2_end_q);

  always_comb begin
    bias_d      = bias_q;
    mult_d      = mult_q;
    shift_d     = shift_q;
    relu_d      = relu_q;
    uns_d       = uns_q;
    sat_d       = sat_q;
    idx_d       = idx_q;
    s1_valid_d  = s1_valid_q;
    s1_prod_d   = s1_prod_q;
    s1_lane_d   = s1_lane_q;
    s1_end_d    = s1_end_q;
    s2_valid_d  = s2_valid_q;
    s2_byte_d   = s2_byte_q;
    s2_lane_d   = s2_lane_q;
    s2_end_d    = s2_end_q;
    pack_d      = pack_q;
    pack_vld_d  = pack_vld_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;

    if (advance) begin
      s1_valid_d = accept;
      if (accept) begin
        s1_prod_d = prod;
        s1_lane_d = idx_q[1:0];
        s1_end_d  = frame_end;
        idx_d     = frame_end ? '0 : idx_q + 1'b1;
      end

      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        s2_byte_d = q_byte;
        s2_lane_d = s1_lane_q;
        s2_end_d  = s1_end_q;
        if (q_clamped && (sat_q != 16'hFFFF)) begin
          sat_d = sat_q + 16'd1;
        end
      end

      out_valid_d = emit;
      if (s2_valid_q) begin
        if (emit) begin
          out_data_d = merged;
          out_last_d = s2_end_q;
          pack_d     = '0;
          pack_vld_d = 1'b0;
        end else begin
          pack_d     = merged;
          pack_vld_d = 1'b1;
        end
      end
    end

    if (cfg_ok) begin
      if (cfg_addr < 4'd8) begin
        bias_d[cfg_addr[2:0]] = cfg_wdata;
      end else if (cfg_addr == 4'd8) begin
        mult_d = cfg_wdata[MULT_W-1:0];
      end else if (cfg_addr == 4'd9) begin
        shift_d = cfg_wdata[4:0];
      end else begin
        relu_d = cfg_wdata[0];
        uns_d  = cfg_wdata[1];
      end
    end

    // Clear is accepted even mid-frame and overrides a same-cycle increment.
    if (cfg_we && (cfg_addr == 4'd11)) begin
      sat_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(NROWS); i++) begin
        bias_q[i] <= '0;
      end
      mult_q      <= MULT_W'(1);
      shift_q     <= '0;
      relu_q      <= 1'b0;
      uns_q       <= 1'b0;
      sat_q       <= '0;
      idx_q       <= '0;
      s1_valid_q  <= 1'b0;
      s1_prod_q   <= '0;
      s1_lane_q   <= '0;
      s1_end_q    <= 1'b0;
      s2_valid_q  <= 1'b0;
      s2_byte_q   <= '0;
      s2_lane_q   <= '0;
      s2_end_q    <= 1'b0;
      pack_q      <= '0;
      pack_vld_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
    end else begin
      bias_q      <= bias_d;
      mult_q      <= mult_d;
      shift_q     <= shift_d;
      relu_q      <= relu_d;
      uns_q       <= uns_d;
      sat_q       <= sat_d;
      idx_q       <= idx_d;
      s1_valid_q  <= s1_valid_d;
      s1_prod_q   <= s1_prod_d;
      s1_lane_q   <= s1_lane_d;
      s1_end_q    <= s1_end_d;
      s2_valid_q  <= s2_valid_d;
      s2_byte_q   <= s2_byte_d;
      s2_lane_q   <= s2_lane_d;
      s2_end_q    <= s2_end_d;
      pack_q      <= pack_d;
      pack_vld_q  <= pack_vld_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
    end
  end

endmodule
